// File: rtl/johnson_decoder.sv
// Johnson code receiver: decodes phase index, checks legality and succession,
// and tracks lock with a saturating error counter.
module johnson_decoder #(
  parameter int N = 4,
  parameter int LOCK_CNT = 3,
  localparam int IW = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  code_in,
  input  logic          code_valid,
  input  logic          clr_err,
  output logic [IW-1:0] index,
  output logic          index_valid,
  output logic          illegal,
  output logic          step_err,
  output logic          wrap,
  output logic          locked,
  output logic [7:0]    err_count
);

  localparam int RW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT,
    TRACK,
    LOCKED
  } state_t;

  state_t state, state_n;
  logic [IW-1:0] prev, prev_n;
  logic [RW-1:0] run, run_n;
  logic [IW-1:0] index_n;
  logic iv_n, ill_n, se_n, wrap_n, err_ev;

  logic [IW-1:0] ones, edges, dec, succ;
  logic legal, bad, fresh, good, skip;

  // Legal Johnson codes have at most one bit transition across the word.
  always_comb begin
    ones = '0;
    edges = '0;
    for (int i = 0; i < N; i++)
      ones = ones + IW'(code_in[i]);
    for (int i = 0; i < N - 1; i++)
      edges = edges + IW'(code_in[i+1] ^ code_in[i]);
  end

  assign legal = (edges <= IW'(1));
  assign dec = (code_in[N-1] || ones == '0)
             ? ones : IW'(2 * N) - ones;
  assign succ = (prev == IW'(2 * N - 1))
              ? '0 : prev + IW'(1);

  assign bad   = !legal;
  assign fresh = legal && state == HUNT;
  assign good  = legal && state != HUNT && dec == succ;
  assign skip  = legal && state != HUNT && dec != succ;

  always_comb begin
    state_n = state;
    prev_n  = prev;
    run_n   = run;
    index_n = index;
    iv_n    = 1'b0;
    ill_n   = 1'b0;
    se_n    = 1'b0;
    wrap_n  = 1'b0;
    err_ev  = 1'b0;
    if (code_valid) begin
      unique case (1'b1)
        bad: begin
          ill_n   = 1'b1;
          err_ev  = 1'b1;
          state_n = HUNT;
          run_n   = '0;
        end
        fresh: begin
          state_n = TRACK;
          run_n   = '0;
          prev_n  = dec;
          index_n = dec;
          iv_n    = 1'b1;
        end
        good: begin
          prev_n  = dec;
          index_n = dec;
          iv_n    = 1'b1;
          wrap_n  = (dec == '0);
          if (state == TRACK) begin
            run_n = run + RW'(1);
            if (run_n == RW'(LOCK_CNT))
              state_n = LOCKED;
          end
        end
        skip: begin
          se_n    = 1'b1;
          err_ev  = 1'b1;
          state_n = TRACK;
          run_n   = '0;
          prev_n  = dec;
          index_n = dec;
          iv_n    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      prev        <= '0;
      run         <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      step_err    <= 1'b0;
      wrap        <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      prev        <= prev_n;
      run         <= run_n;
      index       <= index_n;
      index_valid <= iv_n;
      illegal     <= ill_n;
      step_err    <= se_n;
      wrap        <= wrap_n;
      locked      <= (state_n == LOCKED);
      if (clr_err)
        err_count <= '0;
      else if (err_ev && err_count != 8'hff)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomized and directed bench for johnson_decoder against a
// table-driven reference model.
module tb_johnson_decoder;
  localparam int N = 4;
  localparam int LC = 3;
  localparam int L = 2 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] code_in = '0;
  logic code_valid = 1'b0;
  logic clr_err = 1'b0;
  logic [2:0] index;
  logic index_valid, illegal, step_err, wrap, locked;
  logic [7:0] err_count;

  johnson_decoder #(.N(N), .LOCK_CNT(LC)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in),
    .code_valid(code_valid), .clr_err(clr_err),
    .index(index), .index_valid(index_valid),
    .illegal(illegal), .step_err(step_err), .wrap(wrap),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [N-1:0] jc [L];
  int mode, prev, run, errs, e_index;
  bit e_iv, e_ill, e_se, e_wrap;
  int vecs = 0;
  int bad = 0;

  function automatic int lookup(logic [N-1:0] c);
    for (int i = 0; i < L; i++)
      if (jc[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mode = 0; prev = 0; run = 0; errs = 0; e_index = 0;
    e_iv = 0; e_ill = 0; e_se = 0; e_wrap = 0;
  endtask

  task automatic model_step(logic [N-1:0] c, bit v, bit clr);
    int k;
    e_iv = 0; e_ill = 0; e_se = 0; e_wrap = 0;
    if (v) begin
      k = lookup(c);
      if (k < 0) begin
        e_ill = 1; mode = 0; run = 0;
        if (errs < 255) errs++;
      end else begin
        e_index = k; e_iv = 1;
        if (mode == 0) begin
          mode = 1; run = 0;
        end else if (k == (prev + 1) % L) begin
          e_wrap = (prev == L - 1);
          if (mode == 1) begin
            run++;
            if (run == LC) mode = 2;
          end
        end else begin
          e_se = 1; mode = 1; run = 0;
          if (errs < 255) errs++;
        end
        prev = k;
      end
    end
    if (clr) errs = 0;
  endtask

  task automatic apply(logic [N-1:0] c, bit v, bit clr);
    @(negedge clk);
    code_in = c; code_valid = v; clr_err = clr;
    @(posedge clk);
    #1;
    model_step(c, v, clr);
    code_valid = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic relock();
    apply(4'b0001, 1, 0); apply(4'b0000, 1, 0);
    apply(4'b1000, 1, 0); apply(4'b1100, 1, 0);
  endtask

  task automatic test_reset();
    do_reset();
    apply(4'b0101, 1, 0);
    relock();
    #2 rst_n = 0;
    model_reset();
    #1;
    vecs++;
    if ({index, index_valid, illegal, step_err, wrap, locked, err_count} !== '0) begin
      bad++;
      $display("FAIL reset_async idx=%0d iv=%b il=%b se=%b wr=%b lk=%b err=%0d want all 0",
        index, index_valid, illegal, step_err, wrap, locked, err_count);
    end
    @(negedge clk);
    rst_n = 1;
    apply(4'b1100, 1, 0);
    vecs++;
    if (index !== 3'd2 || index_valid !== 1'b1 || step_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_first idx=%0d iv=%b se=%b want 2 1 0", index, index_valid, step_err);
    end
  endtask

  task automatic test_clean_lock();
    logic [N-1:0] seq [4];
    int xi [4];
    bit xw [4], xl [4];
    seq = '{4'b0001, 4'b0000, 4'b1000, 4'b1100};
    xi = '{7, 0, 1, 2};
    xw = '{0, 1, 0, 0};
    xl = '{0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(seq[i], 1, 0);
      vecs++;
      if (index !== 3'(xi[i]) || wrap !== xw[i] || locked !== xl[i] || err_count !== 8'd0) begin
        bad++;
        $display("FAIL clean_%0d idx=%0d wr=%b lk=%b err=%0d want %0d %b %b 0",
          i, index, wrap, locked, err_count, xi[i], xw[i], xl[i]);
      end
    end
  endtask

  task automatic test_illegal_locked();
    apply(4'b0101, 1, 0);
    vecs++;
    if (illegal !== 1'b1 || index_valid !== 1'b0 || index !== 3'd2 ||
        locked !== 1'b0 || err_count !== 8'd1) begin
      bad++;
      $display("FAIL illegal_locked il=%b iv=%b idx=%0d lk=%b err=%0d want 1 0 2 0 1",
        illegal, index_valid, index, locked, err_count);
    end
    apply(4'b1110, 1, 0);
    vecs++;
    if (step_err !== 1'b0 || index_valid !== 1'b1 || index !== 3'd3) begin
      bad++;
      $display("FAIL illegal_rehunt se=%b iv=%b idx=%0d want 0 1 3", step_err, index_valid, index);
    end
  endtask

  task automatic test_skip();
    logic [N-1:0] seq [3];
    bit xl [3];
    seq = '{4'b0111, 4'b0011, 4'b0001};
    xl = '{0, 0, 1};
    do_reset();
    relock();
    apply(4'b1111, 1, 0);
    vecs++;
    if (step_err !== 1'b1 || index !== 3'd4 || locked !== 1'b0 || err_count !== 8'd1) begin
      bad++;
      $display("FAIL skip se=%b idx=%0d lk=%b err=%0d want 1 4 0 1",
        step_err, index, locked, err_count);
    end
    for (int i = 0; i < 3; i++) begin
      apply(seq[i], 1, 0);
      vecs++;
      if (locked !== xl[i] || step_err !== 1'b0) begin
        bad++;
        $display("FAIL skip_relock_%0d lk=%b se=%b want %b 0", i, locked, step_err, xl[i]);
      end
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 5; i++) begin
      apply(4'b0101, 0, 0);
      vecs++;
      if ({index_valid, illegal, step_err, wrap} !== 4'b0 || locked !== 1'b1) begin
        bad++;
        $display("FAIL gap_%0d pulses=%b lk=%b want 0000 1",
          i, {index_valid, illegal, step_err, wrap}, locked);
      end
    end
    apply(4'b0000, 1, 0);
    vecs++;
    if (index_valid !== 1'b1 || wrap !== 1'b1 || step_err !== 1'b0 ||
        locked !== 1'b1 || err_count !== 8'd1) begin
      bad++;
      $display("FAIL gap_resume iv=%b wr=%b se=%b lk=%b err=%0d want 1 1 0 1 1",
        index_valid, wrap, step_err, locked, err_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++)
      apply(4'b1010, 1, 0);
    vecs++;
    if (err_count !== 8'd255) begin
      bad++;
      $display("FAIL sat err=%0d want 255", err_count);
    end
    apply(4'b1010, 1, 1);
    vecs++;
    if (err_count !== 8'd0 || illegal !== 1'b1) begin
      bad++;
      $display("FAIL sat_clear err=%0d il=%b want 0 1", err_count, illegal);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] c;
    bit v, clr;
    int r;
    logic [15:0] got, want;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 7 && mode != 0) c = jc[(prev + 1) % L];
      else if (r < 9) c = jc[$urandom_range(0, L - 1)];
      else c = N'($urandom);
      clr = ($urandom_range(0, 19) == 0);
      apply(c, v, clr);
      got = {index, index_valid, illegal, step_err, wrap, locked, err_count};
      want = {3'(e_index), e_iv, e_ill, e_se, e_wrap, mode == 2, 8'(errs)};
      vecs++;
      if (got !== want) begin
        bad++;
        $display("FAIL random_%0d code=%b v=%b got=%h want=%h", n, c, v, got, want);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < L; k++) begin
      jc[k] = '0;
      if (k <= N) for (int j = 0; j < k; j++) jc[k][N-1-j] = 1'b1;
      else for (int j = 0; j < L - k; j++) jc[k][j] = 1'b1;
    end
    model_reset();
    test_reset();
    test_clean_lock();
    test_illegal_locked();
    test_skip();
    test_gaps();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
